// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset default and state encodings for the instruction-fetch stage.
// Imported by inst_fetch so every user agrees on bus sizes and FSM codes.
package inst_fetch_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;

   localparam logic [INST_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [0:0] FETCH     = 1'b0;
   localparam logic [0:0] MISS_WAIT = 1'b1;

   // Instruction addresses are word aligned; redirect targets lose their low bits.
   function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
      return {addr[INST_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the PC into the icache, registers hits toward decode,
// and services misses with a single outstanding memory read followed by an icache fill.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   stall_i,
   input  logic                   jump_i,
   input  logic [INST_ADDR_W-1:0] jump_addr_i,
   output logic [INST_ADDR_W-1:0] icache_raddr_o,
   input  logic                   icache_hit_i,
   input  logic [INST_W-1:0]      icache_inst_i,
   output logic                   icache_we_o,
   output logic [INST_ADDR_W-1:0] icache_waddr_o,
   output logic [INST_W-1:0]      icache_winst_o,
   output logic                   mem_req_o,
   output logic [INST_ADDR_W-1:0] mem_addr_o,
   input  logic                   mem_done_i,
   input  logic [INST_W-1:0]      mem_data_i,
   output logic                   inst_valid_o,
   output logic [INST_W-1:0]      inst_o,
   output logic [INST_ADDR_W-1:0] inst_pc_o
);

   logic [INST_ADDR_W-1:0] pc_q, pc_d;
   logic [0:0]             state_q, state_d;
   logic                   pending_jump_q, pending_jump_d;
   logic                   inst_valid_q, inst_valid_d;
   logic [INST_W-1:0]      inst_q, inst_d;
   logic [INST_ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic                   mem_req_q, mem_req_d;
   logic [INST_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic                   icache_we_q, icache_we_d;
   logic [INST_ADDR_W-1:0] icache_waddr_q, icache_waddr_d;
   logic [INST_W-1:0]      icache_winst_q, icache_winst_d;
   logic                   out_hold;

   assign out_hold = inst_valid_q && stall_i;

   always_comb begin
      pc_d           = pc_q;
      state_d        = state_q;
      pending_jump_d = pending_jump_q;
      inst_valid_d   = inst_valid_q;
      inst_d         = inst_q;
      inst_pc_d      = inst_pc_q;
      mem_req_d      = mem_req_q;
      mem_addr_d     = mem_addr_q;
      icache_we_d    = 1'b0;
      icache_waddr_d = icache_waddr_q;
      icache_winst_d = icache_winst_q;

      // Decode consumes the held instruction unless it is stalling; a hit may reload below.
      if (!out_hold) begin
         inst_valid_d = 1'b0;
      end

      case (state_q)
         FETCH: begin
            if (jump_i) begin
               pc_d         = word_align(jump_addr_i);
               inst_valid_d = 1'b0;
            end else if (icache_we_q) begin
               // Fill cycle: the icache is being written this cycle, so the lookup waits one cycle.
               pc_d = pc_q;
            end else if (icache_hit_i && !out_hold) begin
               inst_d       = icache_inst_i;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               pc_d         = pc_q + 32'd4;
            end else if (!icache_hit_i) begin
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
               state_d    = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (jump_i) begin
               pending_jump_d = 1'b1;
               pc_d           = word_align(jump_addr_i);
               inst_valid_d   = 1'b0;
            end
            // The fill is written even after a redirect: the word is correct for its address.
            if (mem_done_i) begin
               mem_req_d      = 1'b0;
               icache_we_d    = 1'b1;
               icache_waddr_d = mem_addr_q;
               icache_winst_d = mem_data_i;
               state_d        = FETCH;
               pending_jump_d = 1'b0;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q           <= RESET_PC;
         state_q        <= FETCH;
         pending_jump_q <= 1'b0;
         inst_valid_q   <= 1'b0;
         inst_q         <= '0;
         inst_pc_q      <= '0;
         mem_req_q      <= 1'b0;
         mem_addr_q     <= '0;
         icache_we_q    <= 1'b0;
         icache_waddr_q <= '0;
         icache_winst_q <= '0;
      end else if (rdy) begin
         pc_q           <= pc_d;
         state_q        <= state_d;
         pending_jump_q <= pending_jump_d;
         inst_valid_q   <= inst_valid_d;
         inst_q         <= inst_d;
         inst_pc_q      <= inst_pc_d;
         mem_req_q      <= mem_req_d;
         mem_addr_q     <= mem_addr_d;
         icache_we_q    <= icache_we_d;
         icache_waddr_q <= icache_waddr_d;
         icache_winst_q <= icache_winst_d;
      end
   end

   assign icache_raddr_o = pc_q;
   assign icache_we_o    = icache_we_q && rdy;
   assign icache_waddr_o = icache_waddr_q;
   assign icache_winst_o = icache_winst_q;
   assign mem_req_o      = mem_req_q;
   assign mem_addr_o     = mem_addr_q;
   assign inst_valid_o   = inst_valid_q;
   assign inst_o         = inst_q;
   assign inst_pc_o      = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a small icache model, a fixed-latency memory responder,
// and monitors that pop expected deliveries and fills as the DUT presents them.
module tb_inst_fetch;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } fill_t;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        stall_i;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic [31:0] icache_raddr_o;
   logic        icache_hit_i;
   logic [31:0] icache_inst_i;
   logic        icache_we_o;
   logic [31:0] icache_waddr_o;
   logic [31:0] icache_winst_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_done_i;
   logic [31:0] mem_data_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;

   int checks   = 0;
   int failures = 0;

   exp_t  exp_q[$];
   fill_t fill_q[$];

   logic        miss_tag [0:1023];
   logic        filled   [0:1023];
   logic [31:0] fill_data[0:1023];

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .stall_i       (stall_i),
      .jump_i        (jump_i),
      .jump_addr_i   (jump_addr_i),
      .icache_raddr_o(icache_raddr_o),
      .icache_hit_i  (icache_hit_i),
      .icache_inst_i (icache_inst_i),
      .icache_we_o   (icache_we_o),
      .icache_waddr_o(icache_waddr_o),
      .icache_winst_o(icache_winst_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_done_i    (mem_done_i),
      .mem_data_i    (mem_data_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Icache model: every word hits with inst=addr except tagged miss lines until filled.
   assign icache_hit_i  = !miss_tag[icache_raddr_o[11:2]] || filled[icache_raddr_o[11:2]];
   assign icache_inst_i = filled[icache_raddr_o[11:2]] ? fill_data[icache_raddr_o[11:2]] : icache_raddr_o;

   always @(posedge clk) begin
      if (icache_we_o) begin
         filled[icache_waddr_o[11:2]]    <= 1'b1;
         fill_data[icache_waddr_o[11:2]] <= icache_winst_o;
      end
   end

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h10:  return 32'hDEAD_BEEF;
         32'h20:  return 32'hCAFE_0020;
         32'h110: return 32'h1111_1110;
         default: return addr ^ 32'hA5A5_A5A5;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_timeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: got timeout, expected event at %0t", name, $time);
   endtask

   task automatic wait_inst_pc(input logic [31:0] pc, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(inst_valid_o && inst_pc_o == pc) && n < budget);
      if (!(inst_valid_o && inst_pc_o == pc)) note_timeout("wait_inst_pc");
   endtask

   task automatic wait_mem_req(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req_o && n < budget);
      if (!mem_req_o) note_timeout("wait_mem_req");
   endtask

   task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      e.inst = inst;
      e.pc   = pc;
      exp_q.push_back(e);
   endtask

   task automatic push_fill(input logic [31:0] addr, input logic [31:0] data);
      fill_t f;
      f.addr = addr;
      f.data = data;
      fill_q.push_back(f);
   endtask

   // Memory responder: answers each request a fixed 4 cycles later, deferring while rdy is low.
   initial begin
      logic [31:0] addr;
      mem_done_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk);
         if (mem_req_o && !mem_done_i) begin
            addr = mem_addr_o;
            repeat (4) @(posedge clk);
            #2;
            while (!rdy) begin
               @(posedge clk);
               #2;
            end
            mem_done_i = 1'b1;
            mem_data_i = mem_word(addr);
            @(posedge clk);
            #1;
            mem_done_i = 1'b0;
            mem_data_i = '0;
         end
      end
   end

   // Delivery monitor: an instruction is consumed by decode whenever it is valid and not stalled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && inst_valid_o && !stall_i) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_inst_pc", inst_pc_o, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check_output("inst_o", inst_o, e.inst);
               check_output("inst_pc_o", inst_pc_o, e.pc);
            end
         end
      end
   end

   // Fill monitor: each strobe must match the next expected icache write.
   initial begin
      fill_t f;
      forever begin
         @(negedge clk);
         if (icache_we_o) begin
            if (fill_q.size() == 0) begin
               check_output("unexpected_fill_addr", icache_waddr_o, 32'hFFFF_FFFF);
            end else begin
               f = fill_q.pop_front();
               check_output("icache_waddr_o", icache_waddr_o, f.addr);
               check_output("icache_winst_o", icache_winst_o, f.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, expected finish at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         miss_tag[i]  = 1'b0;
         filled[i]    = 1'b0;
         fill_data[i] = '0;
      end
      miss_tag[32'h10 >> 2]  = 1'b1;
      miss_tag[32'h20 >> 2]  = 1'b1;
      miss_tag[32'h110 >> 2] = 1'b1;

      push_exp(32'h0, 32'h0);
      push_exp(32'h4, 32'h4);
      push_exp(32'h8, 32'h8);
      push_exp(32'hC, 32'hC);
      push_exp(32'hDEAD_BEEF, 32'h10);
      push_exp(32'h14, 32'h14);
      push_exp(32'h18, 32'h18);
      push_exp(32'h1C, 32'h1C);
      push_exp(32'h200, 32'h200);
      push_exp(32'h204, 32'h204);
      push_exp(32'h208, 32'h208);
      push_exp(32'h100, 32'h100);
      push_exp(32'h104, 32'h104);
      push_exp(32'h108, 32'h108);
      push_exp(32'h10C, 32'h10C);
      push_exp(32'h1111_1110, 32'h110);
      push_exp(32'h114, 32'h114);
      push_exp(32'h118, 32'h118);

      push_fill(32'h10, 32'hDEAD_BEEF);
      push_fill(32'h20, 32'hCAFE_0020);
      push_fill(32'h110, 32'h1111_1110);

      rst         = 1'b0;
      rdy         = 1'b1;
      stall_i     = 1'b0;
      jump_i      = 1'b0;
      jump_addr_i = '0;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_output("reset_raddr", icache_raddr_o, 32'h0);
      check_output("reset_valid", {31'd0, inst_valid_o}, 32'd0);
      check_output("reset_inst", inst_o, 32'h0);
      check_output("reset_inst_pc", inst_pc_o, 32'h0);
      check_output("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
      check_output("reset_icache_we", {31'd0, icache_we_o}, 32'd0);

      // Stall while 0x8 sits in the output register.
      wait_inst_pc(32'h4, 20);
      @(posedge clk);
      #1;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_output("stall_inst_pc", inst_pc_o, 32'h8);
         check_output("stall_inst", inst_o, 32'h8);
         check_output("stall_raddr", icache_raddr_o, 32'hC);
         @(posedge clk);
      end
      #1;
      stall_i = 1'b0;

      // Miss at 0x10.
      wait_mem_req(40);
      check_output("miss10_mem_addr", mem_addr_o, 32'h10);

      // Redirect to 0x200 while waiting on the miss at 0x20.
      wait_inst_pc(32'h1C, 60);
      wait_mem_req(20);
      check_output("miss20_mem_addr", mem_addr_o, 32'h20);
      @(posedge clk);
      #1;
      jump_i      = 1'b1;
      jump_addr_i = 32'h200;
      @(posedge clk);
      #1;
      jump_i = 1'b0;
      @(negedge clk);
      check_output("miss20_req_held", {31'd0, mem_req_o}, 32'd1);
      check_output("miss20_addr_held", mem_addr_o, 32'h20);

      // Jump to an unaligned target while the held instruction is stalled: it is squashed.
      wait_inst_pc(32'h208, 60);
      @(posedge clk);
      #1;
      jump_i      = 1'b1;
      jump_addr_i = 32'h103;
      stall_i     = 1'b1;
      @(negedge clk);
      check_output("squash_victim_pc", inst_pc_o, 32'h20C);
      @(posedge clk);
      #1;
      jump_i  = 1'b0;
      stall_i = 1'b0;
      @(negedge clk);
      check_output("squash_valid", {31'd0, inst_valid_o}, 32'd0);
      check_output("squash_raddr", icache_raddr_o, 32'h100);

      // Freeze with rdy=0 mid-miss; a jump during the freeze must be ignored.
      wait_inst_pc(32'h10C, 40);
      wait_mem_req(20);
      check_output("miss110_mem_addr", mem_addr_o, 32'h110);
      @(posedge clk);
      #1;
      rdy         = 1'b0;
      jump_i      = 1'b1;
      jump_addr_i = 32'h300;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("freeze_req", {31'd0, mem_req_o}, 32'd1);
         check_output("freeze_addr", mem_addr_o, 32'h110);
         check_output("freeze_raddr", icache_raddr_o, 32'h110);
         check_output("freeze_we", {31'd0, icache_we_o}, 32'd0);
         check_output("freeze_valid", {31'd0, inst_valid_o}, 32'd0);
         @(posedge clk);
         if (i == 0) begin
            #1;
            jump_i = 1'b0;
         end
      end
      #1;
      rdy = 1'b1;

      // Drain the rest of the expected stream, then hold decode so nothing further is consumed.
      begin
         int n = 0;
         do begin
            @(posedge clk);
            #2;
            n++;
         end while (exp_q.size() != 0 && n < 200);
         stall_i = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("exp_queue_left", exp_q.size(), 32'd0);
      check_output("fill_queue_left", fill_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
